led_pattern_player: RTL and testbench

- Sequencer that reads LED patterns out of the synchronous block ROM and drives them onto the LED outputs at a programmable step rate.
- Issues ROM addresses, absorbs the ROM's 1-cycle registered read latency, and holds each pattern for a programmed time.
- Supports up/down sweep plus one-shot or looping playback.
- Sits between the ROM (`rom_addr_o`/`rom_data_i`) and the board LED pins; a controller or button logic drives start/stop.

---
 rtl/led_pattern_player.sv | 172 +++++++++++++++++
 tb/tb_led_pattern_player.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// LED pattern sequencer: walks a synchronous block ROM up or down, presents each
// word on the LEDs and holds it for a programmable number of clocks.
//
// Ports:
//   clk_i        system clock (also clocks the ROM)
//   rst_i        synchronous active-high reset
//   start_i      1-cycle start request, honoured only when idle
//   stop_i       1-cycle abort request, wins over start and over completion
//   loop_i       1 = restart at first address after the end address
//   dir_i        0 = ascend 0..last_addr_i, 1 = descend last_addr_i..0
//   last_addr_i  highest ROM index used in a pass
//   period_i     hold length minus one, in clocks
//   rom_addr_o   registered ROM address
//   rom_data_i   ROM word, valid one clock after rom_addr_o changes
//   led_o        registered LED pattern
//   busy_o       high whenever a run is in progress
//   step_o       1-cycle pulse coincident with led_o taking a new value
//   done_o       1-cycle pulse when a one-shot run completes
module led_pattern_player #(
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned DATA_WIDTH   = 4,
   parameter int unsigned PERIOD_WIDTH = 26
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic                    loop_i,
   input  logic                    dir_i,
   input  logic [ADDR_WIDTH-1:0]   last_addr_i,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   output logic [ADDR_WIDTH-1:0]   rom_addr_o,
   input  logic [DATA_WIDTH-1:0]   rom_data_i,
   output logic [DATA_WIDTH-1:0]   led_o,
   output logic                    busy_o,
   output logic                    step_o,
   output logic                    done_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LATCH = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   led_q, led_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    step_q, step_d;
   logic                    done_q, done_d;

   // Run configuration, captured at start so mid-run input changes are ignored
   logic                    loop_q, loop_d;
   logic                    dir_q, dir_d;
   logic [ADDR_WIDTH-1:0]   last_q, last_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;

   logic [ADDR_WIDTH-1:0]   first_addr;
   logic [ADDR_WIDTH-1:0]   end_addr;

   // First/end address of a pass follow the latched direction
   assign first_addr = dir_q ? last_q : '0;
   assign end_addr   = dir_q ? '0 : last_q;

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         led_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         step_q   <= 1'b0;
         done_q   <= 1'b0;
         loop_q   <= 1'b0;
         dir_q    <= 1'b0;
         last_q   <= '0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         led_q    <= led_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         step_q   <= step_d;
         done_q   <= done_d;
         loop_q   <= loop_d;
         dir_q    <= dir_d;
         last_q   <= last_d;
         period_q <= period_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      led_d    = led_q;
      cnt_d    = cnt_q;
      step_d   = 1'b0;
      done_d   = 1'b0;
      loop_d   = loop_q;
      dir_d    = dir_q;
      last_d   = last_q;
      period_d = period_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               loop_d   = loop_i;
               dir_d    = dir_i;
               last_d   = last_addr_i;
               period_d = period_i;
               addr_d   = dir_i ? last_addr_i : '0;
               state_d  = S_FETCH;
            end
         end

         // ROM registers the word addressed by addr_q this cycle
         S_FETCH: begin
            state_d = stop_i ? S_IDLE : S_LATCH;
         end

         S_LATCH: begin
            if (stop_i) begin
               state_d = S_IDLE;
            end else begin
               led_d   = rom_data_i;
               step_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (stop_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == period_q) begin
               // End check precedes inc/dec, so the address never wraps
               if (addr_q == end_addr) begin
                  if (loop_q) begin
                     addr_d  = first_addr;
                     state_d = S_FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  addr_d  = dir_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
                  state_d = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign rom_addr_o = addr_q;
   assign led_o      = led_q;
   assign busy_o     = busy_q;
   assign step_o     = step_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// Self-checking bench for led_pattern_player with a behavioural ROM and an
// arithmetic reference model of the step/done/busy schedule.
module tb_led_pattern_player;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 4;
   localparam int unsigned PW = 26;

   logic          clk = 1'b0;
   logic          rst, start, stop, loop_m, dir;
   logic [AW-1:0] last_addr;
   logic [PW-1:0] period;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] led;
   logic          busy, step, done;

   always #5 clk = ~clk;

   led_pattern_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loop_m),
      .dir_i(dir), .last_addr_i(last_addr), .period_i(period),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .led_o(led),
      .busy_o(busy), .step_o(step), .done_o(done)
   );

   // Synchronous ROM with one clock of read latency
   logic [DW-1:0] mem [32];
   always @(posedge clk) rom_data <= mem[rom_addr];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: a run started at edge t0 has step period S=P+3; the
   // address for step k is fetched at rel=k*S and shown at rel=k*S+2; a
   // one-shot of N=last+1 steps finishes at rel=N*S.
   bit            m_active = 1'b0;
   int            m_t0, m_P, m_last;
   bit            m_dir, m_loop;
   logic [DW-1:0] e_led = '0;
   logic [AW-1:0] e_addr = '0;
   bit            e_step = 1'b0, e_done = 1'b0, e_busy = 1'b0;

   int            n_steps = 0, n_done = 0;
   logic [DW-1:0] step_log [$];

   function automatic logic [AW-1:0] addr_of(int k);
      int n = m_last + 1;
      int j = m_loop ? (k % n) : k;
      return m_dir ? AW'(m_last - j) : AW'(j);
   endfunction

   task automatic model_edge();
      bit was_active = m_active;
      int rel, s, n, k;
      e_step = 1'b0;
      e_done = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         e_led = '0; e_addr = '0; e_busy = 1'b0;
         return;
      end
      if (m_active) begin
         rel = cyc - m_t0;
         s   = m_P + 3;
         n   = m_last + 1;
         if (stop) begin
            m_active = 1'b0;
            e_busy   = 1'b0;
         end else if (rel % s == 0) begin
            k = rel / s;
            if (!m_loop && k == n) begin
               m_active = 1'b0;
               e_busy   = 1'b0;
               e_done   = 1'b1;
            end else begin
               e_addr = addr_of(k);
            end
         end else if (rel % s == 2) begin
            e_led  = mem[e_addr];
            e_step = 1'b1;
         end
      end
      if (!was_active && start && !stop) begin
         m_P = int'(period); m_last = int'(last_addr);
         m_dir = dir; m_loop = loop_m;
         m_t0 = cyc; m_active = 1'b1;
         e_busy = 1'b1;
         e_addr = addr_of(0);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Advance one clock, update the model, then compare away from the edge
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      if (step) begin n_steps++; step_log.push_back(led); end
      if (done) n_done++;
      chk("led",  32'(led),      32'(e_led));
      chk("addr", 32'(rom_addr), 32'(e_addr));
      chk("busy", 32'(busy),     32'(e_busy));
      chk("step", 32'(step),     32'(e_step));
      chk("done", 32'(done),     32'(e_done));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic set_cfg(input int la, input int p, input bit lp, input bit d);
      last_addr = AW'(la); period = PW'(p); loop_m = lp; dir = d;
   endtask

   task automatic clear_counts();
      n_steps = 0; n_done = 0; step_log.delete();
   endtask

   initial begin
      logic [DW-1:0] want [4];
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      set_cfg(0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) mem[i] = DW'(i + 1);

      // Reset then idle with no start
      ticks(2);
      rst = 1'b0;
      ticks(20);

      // Ascending one-shot 1,2,3,4
      clear_counts();
      set_cfg(3, 1, 1'b0, 1'b0);
      pulse_start();
      ticks(22);
      chk("asc_steps", 32'(n_steps), 32'd4);
      chk("asc_done",  32'(n_done),  32'd1);
      want[0] = 4'd1; want[1] = 4'd2; want[2] = 4'd3; want[3] = 4'd4;
      for (int i = 0; i < 4; i++)
         if (i < step_log.size()) chk("asc_seq", 32'(step_log[i]), 32'(want[i]));

      // Descending loop 3,2,1,... for ten steps
      clear_counts();
      set_cfg(2, 0, 1'b1, 1'b1);
      pulse_start();
      ticks(31);
      chk("loop_nodone", 32'(n_done), 32'd0);
      chk("loop_steps",  32'(n_steps), 32'd10);
      pulse_stop();
      ticks(3);

      // Abort mid-HOLD on 2nd step, with an ignored start while busy
      clear_counts();
      set_cfg(3, 3, 1'b0, 1'b0);
      pulse_start();
      ticks(3);
      pulse_start();
      ticks(5);
      pulse_stop();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_led",  32'(led),  32'd2);
      ticks(10);
      chk("abort_nodone", 32'(n_done), 32'd0);

      // Simultaneous start and stop while idle
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("ss_busy", 32'(busy), 32'd0);
      ticks(3);

      // Reset mid-HOLD, then single-step one-shot
      set_cfg(3, 3, 1'b0, 1'b0);
      pulse_start();
      ticks(4);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_led", 32'(led), 32'd0);
      clear_counts();
      set_cfg(0, 2, 1'b0, 1'b0);
      pulse_start();
      ticks(10);
      chk("one_steps", 32'(n_steps), 32'd1);
      chk("one_done",  32'(n_done),  32'd1);

      // Parameter latching: inputs change mid-run
      set_cfg(4, 2, 1'b0, 1'b0);
      pulse_start();
      ticks(6);
      set_cfg(7, 0, 1'b1, 1'b1);
      ticks(30);

      // Stop on the edge a one-shot would finish: no done
      clear_counts();
      set_cfg(1, 0, 1'b0, 1'b0);
      pulse_start();
      ticks(5);
      pulse_stop();
      ticks(4);
      chk("stopend_nodone", 32'(n_done), 32'd0);

      // Randomised runs against the model
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
         set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                 1'($urandom), 1'($urandom));
         pulse_start();
         for (int c = 0; c < int'($urandom_range(10, 70)); c++) begin
            if ($urandom_range(0, 9) == 0) begin
               dir = 1'($urandom); period = PW'($urandom_range(0, 5));
               last_addr = AW'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 49) == 0) start = 1'b1;
            if ($urandom_range(0, 79) == 0) stop = 1'b1;
            tick();
            start = 1'b0; stop = 1'b0;
         end
         pulse_stop();
         ticks(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
